// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : udp_pkg
// Brief    : Shared header offsets, protocol constants, filter state encoding
//            and flag bundle for udp_rx_filter and its sub-modules.
// Revision : 1.0 - initial release
// ============================================================================
package udp_pkg;

    // Byte offsets from the first byte of the Ethernet frame
    localparam int ETH_DST_OFF      = 0;
    localparam int ETH_TYPE_OFF     = 12;
    localparam int IP_VER_IHL_OFF   = 14;
    localparam int IP_PROTO_OFF     = 23;
    localparam int IP_DST_OFF       = 30;
    localparam int UDP_DST_PORT_OFF = 36;
    localparam int HDR_DECIDE_BYTES = 40;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_REPLAY  = 2'd1,
        ST_PASS    = 2'd2,
        ST_DROP    = 2'd3
    } filt_state_t;

    typedef struct packed {
        logic mac_uc_hi;
        logic mac_bc_hi;
        logic mac_ok;
        logic type_ok;
        logic ihl_ok;
        logic proto_ok;
        logic ip_hi_ok;
        logic ip_ok;
        logic port_ok;
    } hdr_flags_t;

    // Lane 0 carries the lowest byte index, which is the most significant
    function automatic logic [31:0] net_order(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_hdr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : udp_hdr_buffer
// Brief    : DEPTH x WIDTH register file, one synchronous write port and one
//            asynchronous read port, holding header beats until the decision.
// Revision : 1.0 - initial release
// ============================================================================
module udp_hdr_buffer
    import udp_pkg::*;
#(
    parameter int DEPTH  = 10,
    parameter int WIDTH  = 36,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/udp_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : udp_rx_filter
// Brief    : Buffers the first DECIDE_WORDS beats of each Ethernet frame,
//            accepts IPv4/UDP frames for LOCAL_MAC/LOCAL_IP/LOCAL_PORT and
//            replays them, otherwise drops them. Define UDP_RX_FILTER_STATS_EN
//            to add accept/drop counters.
// Revision : 1.0 - initial release
// ============================================================================
module udp_rx_filter
    import udp_pkg::*;
#(
    parameter int          AXIS_DATA_WIDTH = 32,
    parameter logic [47:0] LOCAL_MAC       = 48'h020000000001,
    parameter logic [31:0] LOCAL_IP        = 32'hC0A80102,
    parameter logic [15:0] LOCAL_PORT      = 16'd5000,
    parameter int          DECIDE_WORDS    = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         drop_pulse
`ifdef UDP_RX_FILTER_STATS_EN
    ,
    output logic [31:0]                  stat_accept_cnt,
    output logic [31:0]                  stat_drop_cnt
`endif
);

    localparam int c_keep_w = AXIS_DATA_WIDTH / 8;
    localparam int c_buf_w  = AXIS_DATA_WIDTH + c_keep_w;
    localparam int c_idx_w  = $clog2(DECIDE_WORDS);

    localparam logic [c_idx_w-1:0] c_last_idx      = c_idx_w'(DECIDE_WORDS - 1);
    localparam logic [c_idx_w-1:0] c_beat_mac_hi   = c_idx_w'(ETH_DST_OFF / 4);
    localparam logic [c_idx_w-1:0] c_beat_mac_lo   = c_idx_w'(ETH_DST_OFF / 4 + 1);
    localparam logic [c_idx_w-1:0] c_beat_type     = c_idx_w'(ETH_TYPE_OFF / 4);
    localparam logic [c_idx_w-1:0] c_beat_ihl      = c_idx_w'(IP_VER_IHL_OFF / 4);
    localparam logic [c_idx_w-1:0] c_beat_proto    = c_idx_w'(IP_PROTO_OFF / 4);
    localparam logic [c_idx_w-1:0] c_beat_ip_hi    = c_idx_w'(IP_DST_OFF / 4);
    localparam logic [c_idx_w-1:0] c_beat_ip_lo    = c_idx_w'(IP_DST_OFF / 4 + 1);
    localparam logic [c_idx_w-1:0] c_beat_port     = c_idx_w'(UDP_DST_PORT_OFF / 4);

    generate
        if (AXIS_DATA_WIDTH != 32) begin : g_bad_width
            $error("udp_rx_filter: AXIS_DATA_WIDTH must be 32");
        end
        if (DECIDE_WORDS * 4 < HDR_DECIDE_BYTES) begin : g_bad_decide
            $error("udp_rx_filter: DECIDE_WORDS too small to cover the UDP port");
        end
    endgenerate

    filt_state_t          r_state;
    filt_state_t          w_state_nxt;
    logic [c_idx_w-1:0]   r_widx;
    logic [c_idx_w-1:0]   r_ridx;
    hdr_flags_t           r_flags;
    hdr_flags_t           w_flags_nxt;
    logic                 r_drop_pulse;
    logic                 w_drop;
    logic                 w_accept;
    logic                 w_clr;
    logic                 w_buf_we;
    logic                 w_hdr_ok;
    logic [31:0]          w_be;
    logic [c_buf_w-1:0]   w_rd_data;

    assign w_be = net_order(s_axis_tdata);

    udp_hdr_buffer #(
        .DEPTH  (DECIDE_WORDS),
        .WIDTH  (c_buf_w),
        .ADDR_W (c_idx_w)
    ) u_hdr_buffer (
        .clk       (clk),
        .i_wr_en   (w_buf_we),
        .i_wr_addr (r_widx),
        .i_wr_data ({s_axis_tkeep, s_axis_tdata}),
        .i_rd_addr (r_ridx),
        .o_rd_data (w_rd_data)
    );

    // Each header beat updates only the flags whose field it carries
    always_comb begin
        w_flags_nxt = r_flags;
        if (r_state == ST_COLLECT && s_axis_tvalid) begin
            if (r_widx == c_beat_mac_hi) begin
                w_flags_nxt.mac_uc_hi = (w_be == LOCAL_MAC[47:16]);
                w_flags_nxt.mac_bc_hi = (w_be == 32'hFFFF_FFFF);
            end
            if (r_widx == c_beat_mac_lo) begin
                w_flags_nxt.mac_ok = (r_flags.mac_uc_hi && (w_be[31:16] == LOCAL_MAC[15:0])) ||
                                     (r_flags.mac_bc_hi && (w_be[31:16] == 16'hFFFF));
            end
            if (r_widx == c_beat_type) begin
                w_flags_nxt.type_ok = (w_be[31-8*(ETH_TYPE_OFF%4) -: 16] == ETHERTYPE_IPV4);
            end
            if (r_widx == c_beat_ihl) begin
                w_flags_nxt.ihl_ok = (w_be[31-8*(IP_VER_IHL_OFF%4) -: 8] == IPV4_VER_IHL);
            end
            if (r_widx == c_beat_proto) begin
                w_flags_nxt.proto_ok = (w_be[31-8*(IP_PROTO_OFF%4) -: 8] == IP_PROTO_UDP);
            end
            if (r_widx == c_beat_ip_hi) begin
                w_flags_nxt.ip_hi_ok = (w_be[31-8*(IP_DST_OFF%4) -: 16] == LOCAL_IP[31:16]);
            end
            if (r_widx == c_beat_ip_lo) begin
                w_flags_nxt.ip_ok = r_flags.ip_hi_ok && (w_be[31:16] == LOCAL_IP[15:0]);
            end
            if (r_widx == c_beat_port) begin
                w_flags_nxt.port_ok = (w_be[31-8*(UDP_DST_PORT_OFF%4) -: 16] == LOCAL_PORT);
            end
        end
    end

    assign w_hdr_ok = w_flags_nxt.mac_ok & w_flags_nxt.type_ok & w_flags_nxt.ihl_ok &
                      w_flags_nxt.proto_ok & w_flags_nxt.ip_ok & w_flags_nxt.port_ok;

    always_comb begin
        w_state_nxt   = r_state;
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = w_rd_data[AXIS_DATA_WIDTH-1:0];
        m_axis_tkeep  = w_rd_data[c_buf_w-1:AXIS_DATA_WIDTH];
        m_axis_tlast  = 1'b0;
        w_buf_we      = 1'b0;
        w_drop        = 1'b0;
        w_accept      = 1'b0;
        w_clr         = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_buf_we = s_axis_tvalid;
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        w_drop = 1'b1;
                        w_clr  = 1'b1;
                    end else if (r_widx == c_last_idx) begin
                        w_clr = 1'b1;
                        if (w_hdr_ok) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_REPLAY;
                        end else begin
                            w_drop      = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end
                end
            end
            ST_REPLAY: begin
                s_axis_tready = 1'b0;
                m_axis_tvalid = 1'b1;
                if (m_axis_tready && r_ridx == c_last_idx) begin
                    w_state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_COLLECT;
            r_widx       <= '0;
            r_ridx       <= '0;
            r_flags      <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drop_pulse <= w_drop;
            r_flags      <= w_clr ? '0 : w_flags_nxt;
            if (r_state == ST_COLLECT && s_axis_tvalid) begin
                r_widx <= (w_clr) ? '0 : r_widx + 1'b1;
            end
            // ridx wraps to zero after the last buffered beat is replayed
            if (r_state == ST_REPLAY && m_axis_tready) begin
                r_ridx <= (r_ridx == c_last_idx) ? '0 : r_ridx + 1'b1;
            end
        end
    end

    assign drop_pulse = r_drop_pulse;

`ifdef UDP_RX_FILTER_STATS_EN
    logic [31:0] r_stat_accept;
    logic [31:0] r_stat_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_accept <= '0;
            r_stat_drop   <= '0;
        end else begin
            if (w_accept) begin
                r_stat_accept <= r_stat_accept + 32'd1;
            end
            if (w_drop) begin
                r_stat_drop <= r_stat_drop + 32'd1;
            end
        end
    end

    assign stat_accept_cnt = r_stat_accept;
    assign stat_drop_cnt   = r_stat_drop;
`else
    // Without statistics the accept strobe has no consumer
    logic w_accept_unused;
    assign w_accept_unused = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_rx_filter
// Brief    : Self-checking bench for udp_rx_filter against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_udp_rx_filter;

    localparam int          DW   = 10;
    localparam logic [47:0] MAC  = 48'h020000000001;
    localparam logic [31:0] IP   = 32'hC0A80102;
    localparam logic [15:0] PORT = 16'd5000;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        drop_pulse;
`ifdef UDP_RX_FILTER_STATS_EN
    logic [31:0] stat_accept_cnt;
    logic [31:0] stat_drop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int tready_mode = 0;
    int cyc = 0;

    logic [36:0] out_q[$];
    int          out_cyc[$];
    int          s_cyc[$];
    logic [36:0] tx_q[$];
    int drop_total = 0;
    int mvalid_total = 0;
    int s_block_total = 0;
    int stall_viol = 0;

    udp_rx_filter dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .drop_pulse    (drop_pulse)
`ifdef UDP_RX_FILTER_STATS_EN
        ,
        .stat_accept_cnt (stat_accept_cnt),
        .stat_drop_cnt   (stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observer: records handshakes and events seen between edges
    initial begin
        logic [36:0] prev_beat;
        logic        prev_stall;
        prev_beat  = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid) begin
                mvalid_total++;
                if (prev_stall && ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== prev_beat))
                    stall_viol++;
            end
            if (drop_pulse) drop_total++;
            if (s_axis_tvalid && !s_axis_tready) s_block_total++;
            if (s_axis_tvalid && s_axis_tready) s_cyc.push_back(cyc);
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                out_cyc.push_back(cyc);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bytes_t build_frame(int len, bit bcast, int bad);
        bytes_t      f;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] port;
        mac  = MAC;
        ip   = IP;
        port = PORT;
        for (int i = 0; i < 64 || i < len; i++) f.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) f[i] = bcast ? 8'hFF : mac[47-8*i -: 8];
        f[12] = 8'h08; f[13] = 8'h00; f[14] = 8'h45; f[23] = 8'h11;
        for (int i = 0; i < 4; i++) f[30+i] = ip[31-8*i -: 8];
        f[36] = port[15:8];
        f[37] = port[7:0];
        case (bad)
            1: f[$urandom_range(0, 5)] ^= 8'h20;
            2: f[13] = 8'h06;
            3: f[14] = 8'h46;
            4: f[23] = 8'h06;
            5: f[$urandom_range(30, 33)] ^= 8'h01;
            6: f[37] = f[37] + 8'd1;
            default: ;
        endcase
        while (f.size() > len) void'(f.pop_back());
        return f;
    endfunction

    function automatic bit model_accept(bytes_t f);
        logic [47:0] da;
        logic [31:0] dip;
        logic [15:0] et;
        logic [15:0] dp;
        if (f.size() <= 4 * DW) return 1'b0;
        da  = {f[0], f[1], f[2], f[3], f[4], f[5]};
        et  = {f[12], f[13]};
        dip = {f[30], f[31], f[32], f[33]};
        dp  = {f[36], f[37]};
        return (da == MAC || da == 48'hFFFF_FFFF_FFFF) && et == 16'h0800 &&
               f[14] == 8'h45 && f[23] == 8'h11 && dip == IP && dp == PORT;
    endfunction

    task automatic send_frame(input bytes_t f, input int max_beats);
        int nb;
        nb = (f.size() + 3) / 4;
        for (int w = 0; w < nb && w < max_beats; w++) begin
            logic [31:0] d;
            logic [3:0]  k;
            int          t;
            d = $urandom;
            k = '0;
            t = 0;
            for (int l = 0; l < 4; l++) begin
                if (4 * w + l < f.size()) begin
                    d[8*l +: 8] = f[4*w+l];
                    k[l] = 1'b1;
                end
            end
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = (w == nb - 1);
            s_axis_tvalid = 1'b1;
            do begin
                @(negedge clk);
                t++;
            end while (!s_axis_tready && t < 200);
            if (!s_axis_tready) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: beat %0d not accepted, tready=%b required 1", w, s_axis_tready);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            tx_q.push_back({s_axis_tlast, k, d});
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL reset_s_tready: got %b required 1", s_axis_tready); end
        vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %b required 0", m_axis_tvalid); end
        vectors++; if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_m_tlast: got %b required 0", m_axis_tlast); end
        vectors++; if (drop_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_drop_pulse: got %b required 0", drop_pulse); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_accept();
        bytes_t f;
        int s0, c0, d0, n;
        tready_mode = 0;
        @(posedge clk); #1;
        f  = build_frame(64, 0, 0);
        s0 = out_q.size(); c0 = s_cyc.size(); d0 = drop_total;
        tx_q.delete();
        send_frame(f, 1000);
        repeat (3) @(posedge clk); #1;
        n = out_q.size() - s0;
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL accept_count: got %0d beats required 16", n); end
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            vectors++;
            if (out_q[s0+i] !== tx_q[i]) begin miscompares++; $display("FAIL accept_beat[%0d]: got %h required %h", i, out_q[s0+i], tx_q[i]); end
        end
        vectors++;
        if (n < 16 || out_q[s0+15][36] !== 1'b1) begin miscompares++; $display("FAIL accept_tlast: beats %0d, last beat tlast missing, required 1", n); end
        vectors++;
        if (n < 10 || s_cyc.size() < c0 + 10 || out_cyc[s0] - s_cyc[c0+9] !== 1) begin
            miscompares++;
            $display("FAIL accept_latency: got %0d cycles required 1", (n > 0 && s_cyc.size() >= c0 + 10) ? out_cyc[s0] - s_cyc[c0+9] : -1);
        end
        vectors++;
        if (n < 10 || out_cyc[s0+9] - out_cyc[s0] !== 9) begin miscompares++; $display("FAIL replay_rate: 10 replay beats took %0d cycles required 9", n >= 10 ? out_cyc[s0+9] - out_cyc[s0] : -1); end
        vectors++; if (drop_total - d0 !== 0) begin miscompares++; $display("FAIL accept_drop: got %0d pulses required 0", drop_total - d0); end
    endtask

    task automatic test_port_mismatch();
        bytes_t f;
        int v0, d0, b0;
        f  = build_frame(64, 0, 6);
        v0 = mvalid_total; d0 = drop_total; b0 = s_block_total;
        tx_q.delete();
        send_frame(f, 1000);
        repeat (3) @(posedge clk); #1;
        vectors++; if (mvalid_total - v0 !== 0) begin miscompares++; $display("FAIL port_tvalid: got %0d valid cycles required 0", mvalid_total - v0); end
        vectors++; if (drop_total - d0 !== 1) begin miscompares++; $display("FAIL port_drop: got %0d pulses required 1", drop_total - d0); end
        vectors++; if (s_block_total - b0 !== 0) begin miscompares++; $display("FAIL port_tready: got %0d stalled cycles required 0", s_block_total - b0); end
    endtask

    task automatic test_arp_and_short();
        bytes_t f;
        int v0, d0, s0, n;
        v0 = mvalid_total; d0 = drop_total;
        f = build_frame(64, 1, 2);
        send_frame(f, 1000);
        repeat (3) @(posedge clk); #1;
        vectors++; if (drop_total - d0 !== 1) begin miscompares++; $display("FAIL arp_drop: got %0d pulses required 1", drop_total - d0); end
        d0 = drop_total;
        f = build_frame(24, 0, 0);
        send_frame(f, 1000);
        repeat (3) @(posedge clk); #1;
        vectors++; if (drop_total - d0 !== 1) begin miscompares++; $display("FAIL short_drop: got %0d pulses required 1", drop_total - d0); end
        vectors++; if (mvalid_total - v0 !== 0) begin miscompares++; $display("FAIL dropped_tvalid: got %0d valid cycles required 0", mvalid_total - v0); end
        f  = build_frame(64, 1, 0);
        s0 = out_q.size();
        tx_q.delete();
        send_frame(f, 1000);
        repeat (3) @(posedge clk); #1;
        n = out_q.size() - s0;
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL after_short_count: got %0d beats required 16", n); end
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            vectors++;
            if (out_q[s0+i] !== tx_q[i]) begin miscompares++; $display("FAIL after_short_beat[%0d]: got %h required %h", i, out_q[s0+i], tx_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bytes_t f;
        int s0, sv0, n;
        tready_mode = 1;
        f   = build_frame(64, 0, 0);
        s0  = out_q.size(); sv0 = stall_viol;
        tx_q.delete();
        send_frame(f, 1000);
        repeat (3) @(posedge clk); #1;
        tready_mode = 0;
        n = out_q.size() - s0;
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL bp_count: got %0d beats required 16", n); end
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            vectors++;
            if (out_q[s0+i] !== tx_q[i]) begin miscompares++; $display("FAIL bp_beat[%0d]: got %h required %h", i, out_q[s0+i], tx_q[i]); end
        end
        vectors++; if (stall_viol - sv0 !== 0) begin miscompares++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stall_viol - sv0); end
    endtask

    task automatic test_reset_replay();
        bytes_t f;
        int k, t, s0, n;
        tready_mode = 0;
        @(posedge clk); #1;
        f = build_frame(64, 0, 0);
        tx_q.delete();
        send_frame(f, DW);
        k = 0; t = 0;
        while (k < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (m_axis_tvalid && m_axis_tready) k++;
        end
        @(posedge clk); #1;
        vectors++; if (m_axis_tvalid !== 1'b1 || k !== 4) begin miscompares++; $display("FAIL rr_replaying: tvalid %b after %0d beats, required 1 after 4", m_axis_tvalid, k); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rr_tvalid: got %b required 0", m_axis_tvalid); end
        vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL rr_tready: got %b required 1", s_axis_tready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        f  = build_frame(64, 0, 0);
        s0 = out_q.size();
        tx_q.delete();
        send_frame(f, 1000);
        repeat (3) @(posedge clk); #1;
        n = out_q.size() - s0;
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL rr_next_count: got %0d beats required 16", n); end
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            vectors++;
            if (out_q[s0+i] !== tx_q[i]) begin miscompares++; $display("FAIL rr_next_beat[%0d]: got %h required %h", i, out_q[s0+i], tx_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int fr = 0; fr < 24; fr++) begin
            bytes_t f;
            bit     acc;
            int     s0, d0, n, nb;
            tready_mode = $urandom_range(0, 2);
            f   = build_frame($urandom_range(20, 100), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
            acc = model_accept(f);
            nb  = (f.size() + 3) / 4;
            s0  = out_q.size(); d0 = drop_total;
            tx_q.delete();
            send_frame(f, 1000);
            repeat (3) @(posedge clk); #1;
            n = out_q.size() - s0;
            vectors++;
            if (n !== (acc ? nb : 0)) begin miscompares++; $display("FAIL rand%0d_count: got %0d beats required %0d", fr, n, acc ? nb : 0); end
            vectors++;
            if (drop_total - d0 !== (acc ? 0 : 1)) begin miscompares++; $display("FAIL rand%0d_drop: got %0d pulses required %0d", fr, drop_total - d0, acc ? 0 : 1); end
            for (int i = 0; acc && i < n && i < tx_q.size(); i++) begin
                vectors++;
                if (out_q[s0+i] !== tx_q[i]) begin miscompares++; $display("FAIL rand%0d_beat[%0d]: got %h required %h", fr, i, out_q[s0+i], tx_q[i]); end
            end
        end
        tready_mode = 0;
    endtask

`ifdef UDP_RX_FILTER_STATS_EN
    task automatic test_stats();
        bytes_t f;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            f = build_frame(64, 0, (i == 1 || i == 3) ? 6 : 0);
            send_frame(f, 1000);
            repeat (3) @(posedge clk); #1;
        end
        vectors++; if (stat_accept_cnt !== 32'd3) begin miscompares++; $display("FAIL stat_accept: got %0d required 3", stat_accept_cnt); end
        vectors++; if (stat_drop_cnt !== 32'd2) begin miscompares++; $display("FAIL stat_drop: got %0d required 2", stat_drop_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_accept();
        test_port_mismatch();
        test_arp_and_short();
        test_backpressure();
        test_reset_replay();
        test_random();
`ifdef UDP_RX_FILTER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_rx_filter.md
UDP_RX_FILTER -- requirements
Module: udp_rx_filter

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 32, stream width in bits; only 32 is supported, and any other value SHALL be an elaboration error.
REQ-002 Parameter LOCAL_MAC, default 48'h020000000001, unicast destination MAC the block SHALL accept.
REQ-003 Parameter LOCAL_IP, default 32'hC0A80102 (192.168.1.2), destination IPv4 address the block SHALL accept.
REQ-004 Parameter LOCAL_PORT, default 16'd5000, destination UDP port the block SHALL accept.
REQ-005 Parameter DECIDE_WORDS, default 10, number of beats buffered before the accept/drop decision (bytes 0..39).
REQ-006 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  32/4/1/1/1  raw Ethernet frame from the MAC.
REQ-009 m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  32/4/1/1/1  accepted frames, unmodified, to udp_rx.
REQ-010 drop_pulse  output  1  high for one cycle when a frame is rejected.

Function
REQ-011 Byte order: lane k is tdata[8k+7:8k] and carries frame byte 4*w+k of beat w; multi-byte fields SHALL be compared in network order (the lowest byte index is most significant).
REQ-012 Accept iff: bytes 0-5 == LOCAL_MAC or FF:FF:FF:FF:FF:FF; bytes 12-13 == 0x0800; byte 14 == 0x45; byte 23 == 0x11; bytes 30-33 == LOCAL_IP; bytes 36-37 == LOCAL_PORT.
REQ-013 States SHALL be COLLECT, REPLAY, PASS and DROP.
REQ-014 COLLECT: s_axis_tready=1; each accepted beat (data+keep) SHALL be written to buffer index widx, widx++.
REQ-015 COLLECT: tlast on any of beats 0..DECIDE_WORDS-1 SHALL produce drop_pulse on the next cycle and return to COLLECT with widx=0.
REQ-016 COLLECT: on acceptance of beat DECIDE_WORDS-1 without tlast, go to REPLAY if the frame matches; otherwise go to DROP and assert drop_pulse on the next cycle.
REQ-017 REPLAY: s_axis_tready=0; m_axis presents buffer[ridx] with tlast=0; ridx++ on each m_axis handshake; after index DECIDE_WORDS-1 is sent, go to PASS.
REQ-018 PASS: combinational cut-through (m_tdata/tkeep/tlast/tvalid = s_*, s_tready = m_tready); on a tlast handshake, go to COLLECT with widx=ridx=0.
REQ-019 DROP: s_axis_tready=1, m_axis_tvalid=0; on tlast, go to COLLECT.
REQ-020 Latency: the first m_axis beat SHALL be valid on the cycle after beat DECIDE_WORDS-1 is accepted; REPLAY SHALL sustain one beat per cycle while m_axis_tready=1.
REQ-021 m_axis_tvalid SHALL be 0 in COLLECT and DROP; m_tdata/tkeep SHALL be held stable while tvalid=1 and tready=0.
REQ-022 Field matches SHALL be registered as each beat arrives, so that no beat needs more than one word comparison.
REQ-023 tkeep SHALL NOT be checked; it SHALL be forwarded as received.

Reset
REQ-024 rst SHALL force COLLECT, widx=ridx=0, all match flags cleared, m_axis_tvalid=0, m_axis_tlast=0, drop_pulse=0, s_axis_tready=1 on the following cycle, and counters (if present) to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame without emitting tlast; upstream is reset by the same rst, so the next beat is a frame start.

Configuration
REQ-026 Macro UDP_RX_FILTER_STATS_EN SHALL add outputs stat_accept_cnt[31:0] and stat_drop_cnt[31:0]: accept increments on entry to REPLAY, drop increments with drop_pulse; both wrap modulo 2^32.
REQ-027 Without UDP_RX_FILTER_STATS_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package udp_pkg SHALL hold the Ethernet/IP/UDP byte-offset constants, the constants ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11 and IPV4_VER_IHL=8'h45, and the filter state enum.
REQ-029 Sub-module udp_hdr_buffer SHALL provide a DECIDE_WORDS x 36-bit register file with one write port and one read port.

Verification
REQ-030 Matching 64-byte frame to 192.168.1.2:5000, m_tready=1 -> all 16 beats appear unchanged, first output on cycle after beat 9 accepted, tlast on beat 15, drop_pulse=0.
REQ-031 Same frame with dst port 5001 -> no m_axis_tvalid, drop_pulse=1 once, s_axis_tready=1 throughout.
REQ-032 Broadcast MAC, ethertype 0x0806 -> dropped; 24-byte frame with tlast on beat 5 -> dropped, next frame accepted.
REQ-033 Matching frame with m_tready toggling 1,0,1,0 -> output beats identical and in order, tdata stable while stalled, no beat lost or duplicated.
REQ-034 rst asserted during REPLAY at ridx=4 -> tvalid=0 next cycle, state COLLECT; the following matching frame passes intact.
REQ-035 With UDP_RX_FILTER_STATS_EN, 3 accepted and 2 rejected frames -> stat_accept_cnt=3, stat_drop_cnt=2.
